// File: rtl/sched_pkg.sv
// Shared constants, FSM state type and round-robin pick for the sample slot scheduler.
package sched_pkg;

  localparam int unsigned DefDivFactor = 26;
  localparam int unsigned DefSlotTicks = 1000;
  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned MaxReq       = 8;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } sched_state_e;

  // First set bit of req searching upward from ptr, wrapping modulo n. Returns ptr if none set.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < int'(MaxReq); i++) begin
      idx = 3'((int'(ptr) + i) % int'(n));
      if (!found && (i < int'(n)) && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a registered one-cycle tick every DIV_FACTOR clocks.
module tick_prescaler
  import sched_pkg::*;
#(
  parameter int unsigned DIV_FACTOR = DefDivFactor
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned        CntW   = $clog2(DIV_FACTOR);
  localparam logic [CntW-1:0]    CntMax = CntW'(DIV_FACTOR - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (cnt_q == CntMax) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/sample_slot_scheduler.sv
// Slot-based round-robin grant of one sampling resource among NUM_REQ requesters.
// Build with SCHED_TIMEOUT_EN to force-release grants that outlive a full slot.
module sample_slot_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned DIV_FACTOR = DefDivFactor,
  parameter int unsigned SLOT_TICKS = DefSlotTicks,
  parameter int unsigned NUM_REQ    = DefNumReq
) (
  input  logic                       CLK_26MHZ_IN,
  input  logic                       RESET_N_IN,
  input  logic                       ENABLE_IN,
  input  logic [NUM_REQ-1:0]         REQ_IN,
  input  logic [NUM_REQ-1:0]         DONE_IN,
  output logic                       TICK_1US_OUT,
  output logic [NUM_REQ-1:0]         GRANT_OUT,
  output logic                       START_OUT,
  output logic                       BUSY_OUT,
  output logic [$clog2(NUM_REQ)-1:0] SLOT_IDX_OUT,
  output logic                       TIMEOUT_OUT
);

  localparam int unsigned      IdxW     = $clog2(NUM_REQ);
  localparam int unsigned      SlotW    = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SLOT_TICKS - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_REQ - 1);

  logic tick;

  tick_prescaler #(
    .DIV_FACTOR(DIV_FACTOR)
  ) u_prescaler (
    .clk_i (CLK_26MHZ_IN),
    .rst_ni(RESET_N_IN),
    .tick_o(tick)
  );

  logic [SlotW-1:0]   slot_q, slot_d;
  logic               boundary;
  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               start_q, start_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [7:0]         req_pad;
  logic [2:0]         ptr_pad;
  logic [2:0]         pick_full;
  logic [IdxW-1:0]    winner;
  logic               timeout_d;

  assign boundary = tick && (slot_q == SlotLast);

  always_comb begin
    slot_d = slot_q;
    if (tick) begin
      slot_d = (slot_q == SlotLast) ? '0 : slot_q + 1'b1;
    end
  end

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = REQ_IN;
    ptr_pad                = '0;
    ptr_pad[IdxW-1:0]      = ptr_q;
    pick_full              = rr_pick(req_pad, ptr_pad, NUM_REQ);
  end

  assign winner = pick_full[IdxW-1:0];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    start_d   = 1'b0;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (boundary && ENABLE_IN && (|REQ_IN)) begin
          state_d         = StBusy;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          start_d         = 1'b1;
          idx_d           = winner;
          ptr_d           = (winner == IdxLast) ? '0 : winner + 1'b1;
        end
      end
      StBusy: begin
        // DONE wins over a coincident boundary; a released slot waits for the next boundary.
        if (DONE_IN[idx_q]) begin
          state_d = StIdle;
          grant_d = '0;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (boundary) begin
          state_d   = StIdle;
          grant_d   = '0;
          timeout_d = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge CLK_26MHZ_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      slot_q  <= '0;
      state_q <= StIdle;
      grant_q <= '0;
      start_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      state_q <= state_d;
      grant_q <= grant_d;
      start_q <= start_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge CLK_26MHZ_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign TIMEOUT_OUT = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_d;
  assign TIMEOUT_OUT    = 1'b0;
`endif

  assign TICK_1US_OUT = tick;
  assign GRANT_OUT    = grant_q;
  assign START_OUT    = start_q;
  assign BUSY_OUT     = (state_q == StBusy);
  assign SLOT_IDX_OUT = idx_q;

endmodule

// File: tb/tb_sample_slot_scheduler.sv
// Self-checking bench for sample_slot_scheduler (DIV_FACTOR=26, SLOT_TICKS=4, NUM_REQ=4).
module tb_sample_slot_scheduler;

  localparam int Div    = 26;
  localparam int Slot   = 4;
  localparam int Period = Div * Slot;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] done = 4'b0;
  logic       tick, start, busy, timeout;
  logic [3:0] grant;
  logic [1:0] slot_idx;

  int checks = 0;
  int errors = 0;
  int n;
  logic [3:0] exp_q[$];

  sample_slot_scheduler #(
    .DIV_FACTOR(Div),
    .SLOT_TICKS(Slot),
    .NUM_REQ   (4)
  ) dut (
    .CLK_26MHZ_IN(clk),
    .RESET_N_IN  (rst_n),
    .ENABLE_IN   (enable),
    .REQ_IN      (req),
    .DONE_IN     (done),
    .TICK_1US_OUT(tick),
    .GRANT_OUT   (grant),
    .START_OUT   (start),
    .BUSY_OUT    (busy),
    .SLOT_IDX_OUT(slot_idx),
    .TIMEOUT_OUT (timeout)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else n <= n + 1;
  end

  task automatic wait_start(input int budget, output bit got);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (start === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; req = 4'b0; done = 4'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tick, grant, start, busy, slot_idx, timeout} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {tick, grant, start, busy, slot_idx, timeout});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= Period + 10; k++) begin
      @(negedge clk);
      checks++;
      if (tick !== ((k % Div) == 0)) begin
        errors++;
        $display("FAIL tick_edge%0d: got %b want %b", k, tick, ((k % Div) == 0));
      end
      checks++;
      if ({grant, start, busy} !== 6'b0) begin
        errors++;
        $display("FAIL idle_edge%0d: grant/start/busy got %b want 0", k, {grant, start, busy});
      end
    end
  endtask

  task automatic test_round_robin();
    int   exp_idx[3] = '{0, 2, 0};
    bit   got;
    logic [3:0] e;
    req = 4'b0101;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0100); exp_q.push_back(4'b0001);
    for (int g = 0; g < 3; g++) begin
      wait_start(2 * Period, got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL rr_start%0d: got no START want START", g);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (grant !== e || busy !== 1'b1 || slot_idx !== 2'(exp_idx[g])) begin
          errors++;
          $display("FAIL rr_grant%0d: got grant %b busy %b idx %0d want %b 1 %0d",
                   g, grant, busy, slot_idx, e, exp_idx[g]);
        end
        checks++;
        if (((n - 1) % Period) != 0) begin
          errors++;
          $display("FAIL rr_timing%0d: got edge %0d want 1 mod %0d", g, n, Period);
        end
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || grant !== e) begin
          errors++;
          $display("FAIL rr_pulse%0d: got start %b grant %b want 0 %b", g, start, grant, e);
        end
        repeat (3) @(negedge clk);
        done = ~e;
        @(negedge clk);
        done = 4'b0;
        checks++;
        if (grant !== e) begin
          errors++;
          $display("FAIL rr_foreign_done%0d: got %b want %b", g, grant, e);
        end
        repeat (4) @(negedge clk);
        done = e;
        if (g == 2) req = 4'b0;
        @(negedge clk);
        done = 4'b0;
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || slot_idx !== 2'(exp_idx[g])) begin
          errors++;
          $display("FAIL rr_release%0d: got grant %b busy %b idx %0d want 0 0 %0d",
                   g, grant, busy, slot_idx, exp_idx[g]);
        end
      end
    end
  endtask

  task automatic test_mid_slot_request();
    bit got;
    int t0;
    logic [3:0] e;
    while ((n % Period) != 20) @(negedge clk);
    t0 = n;
    req = 4'b1000;
    exp_q.push_back(4'b1000);
    wait_start(2 * Period, got);
    checks++;
    if (!got || (n - t0) != Period - 19) begin
      errors++;
      $display("FAIL mid_slot_timing: got start %b after %0d want 1 after %0d", got, n - t0,
               Period - 19);
    end
    e = exp_q.pop_front();
    checks++;
    if (grant !== e) begin
      errors++;
      $display("FAIL mid_slot_grant: got %b want %b", grant, e);
    end
    repeat (2) @(negedge clk);
    done = 4'b1000; req = 4'b0;
    @(negedge clk);
    done = 4'b0;
  endtask

  task automatic test_enable();
    bit got;
    logic [3:0] e;
    enable = 1'b0; req = 4'b1111;
    for (int k = 0; k < 3 * Period + 10; k++) begin
      @(negedge clk);
      checks++;
      if ({grant, start, busy} !== 6'b0) begin
        errors++;
        $display("FAIL disabled_cyc%0d: got %b want 0", k, {grant, start, busy});
      end
    end
    enable = 1'b1;
    exp_q.push_back(4'b0001);
    wait_start(2 * Period, got);
    enable = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!got || grant !== e) begin
      errors++;
      $display("FAIL enable_grant: got start %b grant %b want 1 %b", got, grant, e);
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== e || busy !== 1'b1) begin
        errors++;
        $display("FAIL enable_hold%0d: got %b %b want %b 1", k, grant, busy, e);
      end
    end
    done = 4'b0001;
    @(negedge clk);
    done = 4'b0;
    for (int k = 0; k < 2 * Period + 10; k++) begin
      checks++;
      if ({grant, start, busy} !== 6'b0) begin
        errors++;
        $display("FAIL enable_after%0d: got %b want 0", k, {grant, start, busy});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_done();
    bit got;
    logic [3:0] e;
    enable = 1'b1; req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_start(2 * Period, got);
    req = 4'b0;
    e = exp_q.pop_front();
    checks++;
    if (!got || grant !== e) begin
      errors++;
      $display("FAIL nodone_grant: got start %b grant %b want 1 %b", got, grant, e);
    end
`ifdef SCHED_TIMEOUT_EN
    for (int k = 1; k <= Period + 1; k++) begin
      @(negedge clk);
      checks++;
      if (k < Period && (grant !== e || timeout !== 1'b0)) begin
        errors++;
        $display("FAIL timeout_hold%0d: got %b %b want %b 0", k, grant, timeout, e);
      end else if (k == Period && ({grant, busy, timeout} !== 6'b000001)) begin
        errors++;
        $display("FAIL timeout_fire: got %b want 000001", {grant, busy, timeout});
      end else if (k > Period && timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_pulse: got %b want 0", timeout);
      end
    end
`else
    for (int k = 1; k <= 5 * Period; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== e || busy !== 1'b1 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL nodone_hold%0d: got %b %b %b want %b 1 0", k, grant, busy, timeout, e);
      end
    end
`endif
  endtask

  task automatic test_async_reset();
    bit got;
    logic [3:0] e;
    if (busy !== 1'b1) begin
      req = 4'b1111; enable = 1'b1;
      wait_start(2 * Period, got);
    end
    req = 4'b1111; enable = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tick, grant, start, busy, slot_idx, timeout} !== 10'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want 0", {tick, grant, start, busy, slot_idx, timeout});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'b0001);
    wait_start(2 * Period, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || grant !== e || slot_idx !== 2'd0 || n != Period + 1) begin
      errors++;
      $display("FAIL post_reset_grant: got %b %b idx %0d edge %0d want 1 %b 0 %0d",
               got, grant, slot_idx, n, e, Period + 1);
    end
    done = 4'b0001; req = 4'b0;
    @(negedge clk);
    done = 4'b0;
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_release: got %b %b want 0 0", grant, busy);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_mid_slot_request();
    test_enable();
    test_no_done();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
